// File: rtl/iq_tx_pkg.sv
// Shared constants for the IQ frame transmitter: buffer geometry, packed-sample
// field layout and the FSM state encoding.
package iq_tx_pkg;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int DATA_W = 12;
  localparam int WGT_W  = 4;
  localparam int WORD_W = 2 * DATA_W + 2 * WGT_W;

  // Packed sample, MSB to LSB: data_i, data_q, w_i, w_q
  localparam int DI_LSB = 2 * WGT_W + DATA_W;
  localparam int DQ_LSB = 2 * WGT_W;
  localparam int WI_LSB = WGT_W;
  localparam int WQ_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/iq_tx_buf.sv
// Frame sample buffer: DEPTH x WORD_W flop array with one synchronous write
// port and a combinational read port.
module iq_tx_buf #(
  parameter int DEPTH  = iq_tx_pkg::DEPTH,
  parameter int AW     = iq_tx_pkg::AW,
  parameter int WORD_W = iq_tx_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: this array is deliberately reset; a frame sent right after reset must
  // read zeros, which is visible behaviour. Storage arrays normally skip reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/iq_frame_tx.sv
// Streams a stored frame of packed I/Q samples into the multiplier pipeline,
// with a programmable idle gap between samples and a done pulse at the end.
module iq_frame_tx #(
  parameter int DEPTH = iq_tx_pkg::DEPTH,
  parameter int AW    = iq_tx_pkg::AW
) (
  input  logic                                 clk,
  input  logic                                 rstb,
  input  logic                                 wr_en,
  input  logic [AW-1:0]                        wr_addr,
  input  logic [iq_tx_pkg::WORD_W-1:0]         wr_data,
  input  logic                                 start,
  input  logic [AW:0]                          len,
  input  logic [2:0]                           gap,
  output logic                                 busy,
  output logic signed [iq_tx_pkg::DATA_W-1:0]  in_data_i,
  output logic signed [iq_tx_pkg::DATA_W-1:0]  in_data_q,
  output logic signed [iq_tx_pkg::WGT_W-1:0]   in_w_i,
  output logic signed [iq_tx_pkg::WGT_W-1:0]   in_w_q,
  output logic                                 in_en,
  output logic                                 done
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  iq_tx_pkg::state_e state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [AW:0]    len_q, len_d;
  logic [2:0]     gap_q, gap_d;
  logic [2:0]     gcnt_q, gcnt_d;
  logic           busy_q, in_en_q, done_q;
  logic [iq_tx_pkg::WORD_W-1:0] word_q, buf_rd, rd_word;
  logic           buf_we;

  assign buf_we = wr_en && !busy_q;

  iq_tx_buf #(.DEPTH(DEPTH), .AW(AW), .WORD_W(iq_tx_pkg::WORD_W)) u_buf (
    .clk     (clk),
    .rstb    (rstb),
    .wr_en   (buf_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (buf_rd)
  );

  // Outputs are loaded one edge ahead, so a write landing on the start edge
  // must be forwarded for the first sample to see it.
  assign rd_word = (buf_we && wr_addr == idx_d) ? wr_data : buf_rd;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      iq_tx_pkg::IDLE: begin
        if (start && len != '0 && len <= LEN_MAX) begin
          len_d   = len;
          gap_d   = gap;
          idx_d   = '0;
          state_d = iq_tx_pkg::SEND;
        end
      end
      iq_tx_pkg::SEND: begin
        if ({1'b0, idx_q} == len_q - (AW+1)'(1)) begin
          state_d = iq_tx_pkg::DONE;
        end else begin
          idx_d = idx_q + AW'(1);
          if (gap_q != 3'd0) begin
            gcnt_d  = gap_q;
            state_d = iq_tx_pkg::GAP;
          end
        end
      end
      iq_tx_pkg::GAP: begin
        if (gcnt_q == 3'd1) begin
          gcnt_d  = 3'd0;
          state_d = iq_tx_pkg::SEND;
        end else begin
          gcnt_d = gcnt_q - 3'd1;
        end
      end
      iq_tx_pkg::DONE: state_d = iq_tx_pkg::IDLE;
      default:         state_d = iq_tx_pkg::IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= iq_tx_pkg::IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      busy_q  <= 1'b0;
      in_en_q <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      busy_q  <= (state_d != iq_tx_pkg::IDLE);
      in_en_q <= (state_d == iq_tx_pkg::SEND);
      done_q  <= (state_d == iq_tx_pkg::DONE);
      word_q  <= (state_d == iq_tx_pkg::SEND) ? rd_word : '0;
    end
  end

  assign busy      = busy_q;
  assign in_en     = in_en_q;
  assign done      = done_q;
  assign in_data_i = word_q[iq_tx_pkg::DI_LSB +: iq_tx_pkg::DATA_W];
  assign in_data_q = word_q[iq_tx_pkg::DQ_LSB +: iq_tx_pkg::DATA_W];
  assign in_w_i    = word_q[iq_tx_pkg::WI_LSB +: iq_tx_pkg::WGT_W];
  assign in_w_q    = word_q[iq_tx_pkg::WQ_LSB +: iq_tx_pkg::WGT_W];

endmodule

// File: tb/tb_iq_frame_tx.sv
// Self-checking bench for iq_frame_tx: directed frames plus random frames,
// compared cycle by cycle against a timing-formula reference model.
module tb_iq_frame_tx;
  import iq_tx_pkg::*;

  logic              clk = 1'b0;
  logic              rstb;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              start;
  logic [AW:0]       len_in;
  logic [2:0]        gap_in;
  logic              busy, in_en, done;
  logic signed [DATA_W-1:0] in_data_i, in_data_q;
  logic signed [WGT_W-1:0]  in_w_i, in_w_q;

  iq_frame_tx dut (
    .clk       (clk),
    .rstb      (rstb),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .len       (len_in),
    .gap       (gap_in),
    .busy      (busy),
    .in_data_i (in_data_i),
    .in_data_q (in_data_q),
    .in_w_i    (in_w_i),
    .in_w_q    (in_w_q),
    .in_en     (in_en),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [WORD_W-1:0] mem_m [DEPTH];
  logic [34:0] obs;

  assign obs = {busy, in_en, done, in_data_i, in_data_q, in_w_i, in_w_q};

  task automatic check(input string tag, input logic [34:0] o, input logic [34:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy,in_en,done,sample} at cycle offset c after the start cycle.
  function automatic logic [34:0] exp_out(input int c, input int len, input int gap);
    int p = gap + 1;
    int done_c = 1 + (len - 1) * p + 1;
    logic [WORD_W-1:0] w = '0;
    logic b, e, d;
    b = (c >= 1) && (c <= done_c);
    d = (c == done_c);
    e = (c >= 1) && ((c - 1) % p == 0) && ((c - 1) / p < len);
    if (e) w = mem_m[(c - 1) / p];
    return {b, e, d, w};
  endfunction

  task automatic write_word(input int a, input logic [WORD_W-1:0] w);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = w;
    tick();
    wr_en = 1'b0;
    mem_m[a] = w;
  endtask

  task automatic run_frame(input int len, input int gap, input bit intrude,
                           input bit wr_same, input logic [WORD_W-1:0] wr_word);
    int done_c = 1 + (len - 1) * (gap + 1) + 1;
    if (wr_same) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = wr_word;
      mem_m[0] = wr_word;
    end
    start = 1'b1; len_in = (AW+1)'(len); gap_in = 3'(gap);
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= done_c + 2; c++) begin
      check($sformatf("frame len%0d gap%0d c%0d", len, gap, c), obs, exp_out(c, len, gap));
      if (intrude && c == 2) begin
        start = 1'b1; len_in = 5'd4; gap_in = 3'd0;
        wr_en = 1'b1; wr_addr = '0; wr_data = $urandom;
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
  endtask

  task automatic bad_start(input int len);
    start = 1'b1; len_in = (AW+1)'(len); gap_in = 3'd0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("ignored len%0d c%0d", len, c), obs, 35'd0);
      tick();
    end
  endtask

  initial begin
    rstb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len_in = '0; gap_in = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    #12;
    check("reset state", obs, 35'd0);
    rstb = 1'b1;
    tick();

    write_word(0, {12'h7FF, 12'h800, 4'h7, 4'h8});
    write_word(1, {12'h001, 12'hFFF, 4'h1, 4'hF});
    write_word(2, {12'h123, 12'h456, 4'h3, 4'h4});
    write_word(3, 32'h0);
    run_frame(4, 0, 1'b0, 1'b0, '0);
    run_frame(3, 2, 1'b0, 1'b0, '0);

    bad_start(0);
    bad_start(17);
    bad_start(31);

    // Write and start on the same edge: frame must read the new word
    run_frame(2, 1, 1'b0, 1'b1, $urandom);

    // Intruding start and write mid-frame must be dropped
    run_frame(4, 0, 1'b1, 1'b0, '0);
    run_frame(1, 0, 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of a frame
    start = 1'b1; len_in = 5'd8; gap_in = 3'd0;
    tick();
    start = 1'b0;
    tick();
    rstb = 1'b0;
    #1;
    check("async reset mid-frame", obs, 35'd0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    tick();
    check("held in reset", obs, 35'd0);
    rstb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("idle after reset c%0d", c), obs, 35'd0);
    end
    run_frame(1, 0, 1'b0, 1'b0, '0);

    // Random buffer contents and random frames
    for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
    for (int r = 0; r < 6; r++)
      run_frame(int'($urandom_range(1, 16)), int'($urandom_range(0, 7)), 1'b0, 1'b0, '0);
    run_frame(16, 7, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
